// File: rtl/decode_pkg.sv
// decode_pkg: immediate-select codes and default widths shared by the decode stage (no ports)
package decode_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_IMD_W = 16;
  localparam int DEF_JADDR_W = 26;
  typedef enum logic [1:0] {
    IMM_ZERO = 2'b00,
    IMM_SIGN = 2'b01,
    IMM_UPPER = 2'b10,
    IMM_ZERO_ALT = 2'b11
  } imm_sel_e;
endpackage

// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: fetch-side handshake + fields, writeback port, ID/EX outputs; slave = stage view, master = driver view
interface decode_stage_pipe_if
  import decode_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMD_W = DEF_IMD_W,
  parameter int JADDR_W = DEF_JADDR_W
);
  logic in_valid, in_ready, flush;
  logic [ADDR_W-1:0] DIR_A, DIR_B, DIR_DST, DIR_WRA;
  logic DST_WR, REG_WR;
  logic [IMD_W-1:0] IMD;
  logic [1:0] IMD_SEL;
  logic [JADDR_W-1:0] JADDR;
  logic [DATA_W-1:0] DI;
  logic out_valid, out_ready;
  logic [DATA_W-1:0] DOA, DOB, out_imm;
  logic [JADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] out_dst;
  logic out_dst_wr, hazard;
  modport slave (
    input in_valid, flush, DIR_A, DIR_B, DIR_DST, DST_WR, IMD, IMD_SEL, JADDR,
    input REG_WR, DIR_WRA, DI, out_ready,
    output in_ready, out_valid, DOA, DOB, out_imm, out_addr, out_dst, out_dst_wr, hazard
  );
  modport master (
    output in_valid, flush, DIR_A, DIR_B, DIR_DST, DST_WR, IMD, IMD_SEL, JADDR,
    output REG_WR, DIR_WRA, DI, out_ready,
    input in_ready, out_valid, DOA, DOB, out_imm, out_addr, out_dst, out_dst_wr, hazard
  );
endinterface

// File: rtl/decode_regfile_2r1w.sv
// decode_regfile_2r1w: 2 async-read/1 write register array (clk, we_n active-low, wra/di write, ra/rb -> doa/dob); R0 reads 0 when ZERO_R0; DECODE_BYPASS_EN forwards di to matching reads
module decode_regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_R0 = 1
) (
  input logic clk,
  input logic we_n,
  input logic [ADDR_W-1:0] wra,
  input logic [DATA_W-1:0] di,
  input logic [ADDR_W-1:0] ra,
  input logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] doa,
  output logic [DATA_W-1:0] dob
);
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic wr_ok;
  assign wr_ok = ~we_n & ~(ZERO_R0 != 0 && wra == '0);
  always_ff @(posedge clk)
    if (wr_ok) mem[wra] <= di;
  always_comb begin
    doa = (ZERO_R0 != 0 && ra == '0) ? '0 : (BYP && wr_ok && wra == ra) ? di : mem[ra];
    dob = (ZERO_R0 != 0 && rb == '0) ? '0 : (BYP && wr_ok && wra == rb) ? di : mem[rb];
  end
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: regfile + immediate extender + pending-write scoreboard behind a valid/ready ID/EX register (reloj, async reset, bus = decode_stage_pipe_if.slave); DECODE_BYPASS_EN enables writeback forwarding
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMD_W = DEF_IMD_W,
  parameter int JADDR_W = DEF_JADDR_W,
  parameter int ZERO_R0 = 1
) (
  input logic reloj,
  input logic reset,
  decode_stage_pipe_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] pend, pend_vis, wb_bit, set_bit, kill_bit;
  logic [DATA_W-1:0] rd_a, rd_b, imm;
  logic accept;
  decode_regfile_2r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .ZERO_R0(ZERO_R0)
  ) u_rf (
    .clk(reloj),
    .we_n(bus.REG_WR),
    .wra(bus.DIR_WRA),
    .di(bus.DI),
    .ra(bus.DIR_A),
    .rb(bus.DIR_B),
    .doa(rd_a),
    .dob(rd_b)
  );
  assign wb_bit = bus.REG_WR ? '0 : DEPTH'(1) << bus.DIR_WRA;
`ifdef DECODE_BYPASS_EN
  assign pend_vis = pend & ~wb_bit;
`else
  assign pend_vis = pend;
`endif
  assign bus.hazard = pend_vis[bus.DIR_A] | pend_vis[bus.DIR_B] | (bus.DST_WR & pend_vis[bus.DIR_DST]);
  assign bus.in_ready = ~bus.flush & ~bus.hazard & (~bus.out_valid | bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  assign set_bit = (accept & bus.DST_WR & ~(ZERO_R0 != 0 && bus.DIR_DST == '0)) ? DEPTH'(1) << bus.DIR_DST : '0;
  assign kill_bit = (bus.flush & bus.out_valid & bus.out_dst_wr) ? DEPTH'(1) << bus.out_dst : '0;
  always_comb
    imm = bus.IMD_SEL == IMM_SIGN ? DATA_W'($signed(bus.IMD)) :
          bus.IMD_SEL == IMM_UPPER ? DATA_W'(bus.IMD) << (DATA_W - IMD_W) : DATA_W'(bus.IMD);
  always_ff @(posedge reloj or posedge reset)
    if (reset) begin
      pend <= '0;
      bus.out_valid <= 1'b0;
      bus.DOA <= '0;
      bus.DOB <= '0;
      bus.out_imm <= '0;
      bus.out_addr <= '0;
      bus.out_dst <= '0;
      bus.out_dst_wr <= 1'b0;
    end else begin
      pend <= (pend & ~wb_bit & ~kill_bit) | set_bit;
      if (bus.flush) bus.out_valid <= 1'b0;
      else if (accept) begin
        bus.out_valid <= 1'b1;
        bus.DOA <= rd_a;
        bus.DOB <= rd_b;
        bus.out_imm <= imm;
        bus.out_addr <= bus.JADDR;
        bus.out_dst <= bus.DIR_DST;
        bus.out_dst_wr <= bus.DST_WR;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed stimulus, per-cycle comparison against a behavioural model, plus literal expectations
module tb_decode_stage_pipe;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  decode_stage_pipe_if bus ();
  decode_stage_pipe dut (
    .reloj(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [31:0] m_mem [32];
  logic [31:0] m_pend;
  logic m_valid, m_dstwr;
  logic [31:0] m_doa, m_dob, m_imm;
  logic [25:0] m_addr;
  logic [4:0] m_dst;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit busy(input logic [4:0] i);
    return m_pend[i] && !(BYP && !bus.REG_WR && bus.DIR_WRA == i);
  endfunction
  function automatic bit m_haz();
    return busy(bus.DIR_A) || busy(bus.DIR_B) || (bus.DST_WR && busy(bus.DIR_DST));
  endfunction
  function automatic bit m_rdy();
    return !bus.flush && !m_haz() && (!m_valid || bus.out_ready);
  endfunction
  function automatic logic [31:0] m_rd(input logic [4:0] i);
    if (i == 0) return 32'h0;
    if (BYP && !bus.REG_WR && bus.DIR_WRA == i) return bus.DI;
    return m_mem[i];
  endfunction
  function automatic logic [31:0] m_ext(input logic [15:0] v, input logic [1:0] s);
    if (s == 2'b01) return {{16{v[15]}}, v};
    if (s == 2'b10) return {v, 16'h0000};
    return {16'h0000, v};
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_pend <= '0;
      m_valid <= 1'b0;
      m_doa <= '0;
      m_dob <= '0;
      m_imm <= '0;
      m_addr <= '0;
      m_dst <= '0;
      m_dstwr <= 1'b0;
    end else begin
      if (!bus.REG_WR) m_pend[bus.DIR_WRA] <= 1'b0;
      if (bus.flush && m_valid && m_dstwr) m_pend[m_dst] <= 1'b0;
      if (bus.in_valid && m_rdy() && bus.DST_WR && bus.DIR_DST != 0) m_pend[bus.DIR_DST] <= 1'b1;
      if (bus.flush) m_valid <= 1'b0;
      else if (bus.in_valid && m_rdy()) begin
        m_valid <= 1'b1;
        m_doa <= m_rd(bus.DIR_A);
        m_dob <= m_rd(bus.DIR_B);
        m_imm <= m_ext(bus.IMD, bus.IMD_SEL);
        m_addr <= bus.JADDR;
        m_dst <= bus.DIR_DST;
        m_dstwr <= bus.DST_WR;
      end else if (bus.out_ready) m_valid <= 1'b0;
      if (!bus.REG_WR && bus.DIR_WRA != 0) m_mem[bus.DIR_WRA] <= bus.DI;
    end
  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, m_valid);
    chk("hazard", bus.hazard, m_haz());
    chk("in_ready", bus.in_ready, m_rdy());
    if (m_valid) begin
      chk("DOA", bus.DOA, m_doa);
      chk("DOB", bus.DOB, m_dob);
      chk("out_imm", bus.out_imm, m_imm);
      chk("out_addr", bus.out_addr, m_addr);
      chk("out_dst", bus.out_dst, m_dst);
      chk("out_dst_wr", bus.out_dst_wr, m_dstwr);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.DST_WR = 1'b0;
    bus.REG_WR = 1'b1;
    bus.out_ready = 1'b1;
  endtask
  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic dw,
                       input logic [15:0] imd, input logic [1:0] sel);
    bus.in_valid = 1'b1;
    bus.DIR_A = a;
    bus.DIR_B = b;
    bus.DIR_DST = d;
    bus.DST_WR = dw;
    bus.IMD = imd;
    bus.IMD_SEL = sel;
    bus.JADDR = {a, b, d, 11'h5A5};
  endtask
  initial begin
    idle();
    issue(0, 0, 0, 0, 16'h0, 2'b00);
    bus.in_valid = 1'b0;
    bus.DIR_WRA = '0;
    bus.DI = '0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_doa", bus.DOA, 0);
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_dstwr", bus.out_dst_wr, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.REG_WR = 1'b0;
      bus.DIR_WRA = 5'(i);
      bus.DI = 32'h1000_0000 + 32'(i * 3);
      cyc();
    end
    bus.DIR_WRA = 5'd5;
    bus.DI = 32'hDEAD_BEEF;
    cyc();
    idle();
    issue(5, 1, 0, 0, 16'h8001, 2'b01);
    cyc();
    idle();
    @(negedge clk);
    chk("t2_doa", bus.DOA, 32'hDEAD_BEEF);
    chk("t2_dob", bus.DOB, 32'h1000_0003);
    chk("t2_valid", bus.out_valid, 1);
    chk("t4_sign", bus.out_imm, 32'hFFFF_8001);
    cyc();
    issue(2, 4, 0, 0, 16'h8001, 2'b00);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_zero", bus.out_imm, 32'h0000_8001);
    chk("t4_doa", bus.DOA, 32'h1000_0006);
    cyc();
    issue(2, 4, 0, 0, 16'h8001, 2'b10);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_upper", bus.out_imm, 32'h8001_0000);
    cyc();
    issue(0, 0, 3, 1, 16'h0003, 2'b00);
    cyc();
    issue(1, 3, 0, 0, 16'h0000, 2'b00);
    @(negedge clk);
    chk("t3_haz", bus.hazard, 1);
    chk("t3_rdy", bus.in_ready, 0);
    cyc();
    bus.REG_WR = 1'b0;
    bus.DIR_WRA = 5'd3;
    bus.DI = 32'h12;
    @(negedge clk);
    chk("t3_wb_haz", bus.hazard, !BYP);
    chk("t3_wb_rdy", bus.in_ready, BYP);
    cyc();
    bus.REG_WR = 1'b1;
    @(negedge clk);
    chk("t3_after_haz", bus.hazard, 0);
    chk("t3_early", bus.out_valid, BYP);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_dob", bus.DOB, 32'h12);
    chk("t3_valid", bus.out_valid, 1);
    cyc();
    bus.out_ready = 1'b0;
    issue(5, 0, 0, 0, 16'h1234, 2'b00);
    cyc();
    issue(1, 2, 0, 0, 16'h4321, 2'b00);
    @(negedge clk);
    chk("t5_rdy", bus.in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("t5_hold_doa", bus.DOA, 32'hDEAD_BEEF);
      chk("t5_hold_imm", bus.out_imm, 32'h0000_1234);
    end
    cyc();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_rdy_back", bus.in_ready, 1);
    cyc();
    idle();
    @(negedge clk);
    chk("t5_next_doa", bus.DOA, 32'h1000_0003);
    chk("t5_next_imm", bus.out_imm, 32'h0000_4321);
    cyc();
    bus.out_ready = 1'b0;
    issue(0, 0, 7, 1, 16'h0, 2'b00);
    cyc();
    bus.in_valid = 1'b0;
    bus.DST_WR = 1'b0;
    @(negedge clk);
    chk("t6_dst", bus.out_dst, 7);
    chk("t6_dstwr", bus.out_dst_wr, 1);
    cyc();
    issue(7, 0, 0, 0, 16'h0, 2'b00);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_rdy", bus.in_ready, 0);
    cyc();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_killed", bus.out_valid, 0);
    chk("t6_r7_haz", bus.hazard, 0);
    cyc();
    idle();
    @(negedge clk);
    chk("t6_r7", bus.DOA, 32'h1000_0015);
    cyc();
    bus.REG_WR = 1'b0;
    bus.DIR_WRA = 5'd0;
    bus.DI = 32'hFFFF_FFFF;
    cyc();
    idle();
    issue(0, 0, 0, 1, 16'h0, 2'b00);
    cyc();
    issue(0, 0, 0, 0, 16'h0, 2'b00);
    @(negedge clk);
    chk("t6_r0_haz", bus.hazard, 0);
    cyc();
    idle();
    @(negedge clk);
    chk("t6_r0", bus.DOA, 0);
    cyc();
    bus.out_ready = 1'b0;
    issue(0, 0, 9, 1, 16'h0, 2'b00);
    cyc();
    issue(9, 0, 0, 0, 16'h0, 2'b00);
    @(negedge clk);
    chk("t1_stall", bus.hazard, 1);
    cyc();
    rst = 1'b1;
    #1;
    chk("t1_valid", bus.out_valid, 0);
    chk("t1_haz", bus.hazard, 0);
    chk("t1_dst", bus.out_dst, 0);
    chk("t1_dstwr", bus.out_dst_wr, 0);
    bus.in_valid = 1'b0;
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_rdy", bus.in_ready, 1);
    chk("t1_valid_rel", bus.out_valid, 0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
